// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the five-stage MIPS core: ID decode, load-use stall,
// branch/jr redirect, EX forwarding selects and stage-aligned control bundles.
module pipe_ctrl_unit #(
   parameter int unsigned ALUOP_W = 5,
   parameter int unsigned RA_W    = 5,
   parameter bit          FWD_EN  = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funcode,
   input  logic [RA_W-1:0]    id_rs,
   input  logic [RA_W-1:0]    id_rt,
   input  logic [RA_W-1:0]    id_rd,
   input  logic               branch_taken,
   output logic               pc_write,
   output logic               ifid_write,
   output logic               ifid_flush,
   output logic [1:0]         pc_src,
   output logic               illegal_instr,
   output logic               ex_valid,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_alu_src,
   output logic [1:0]         ex_fwd_a,
   output logic [1:0]         ex_fwd_b,
   output logic               mem_mem_read,
   output logic               mem_mem_write,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic [RA_W-1:0]    wb_waddr
);

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SUB  = 5'b00001,
      ALU_AND  = 5'b00010,
      ALU_OR   = 5'b00011,
      ALU_NOR  = 5'b00100,
      ALU_SLL  = 5'b00101,
      ALU_SRL  = 5'b00110,
      ALU_SRA  = 5'b00111,
      ALU_SLT  = 5'b01000,
      ALU_LUI  = 5'b01001,
      ALU_BNE  = 5'b01010,
      ALU_BGTZ = 5'b01011,
      ALU_BGEZ = 5'b01100
   } alu_e;

   // Control bundle carried from ID into EX; a bubble is all zeros.
   typedef struct packed {
      logic               reg_write;
      logic               mem_to_reg;
      logic               mem_read;
      logic               mem_write;
      logic               alu_src;
      logic               is_branch;
      logic               is_jr;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

   ctrl_t           w_dec;
   alu_e            w_alu;
   logic            w_known;
   logic            w_imm_arith;
   logic            w_reg_dst;
   logic            w_rt_src;
   logic [RA_W-1:0] w_dest;
   logic            w_load_use;
   logic            w_redir_br;
   logic            w_redir_jr;
   logic            w_id_bubble;

   logic            r_ex_valid;
   ctrl_t           r_ex;
   logic [RA_W-1:0] r_ex_dest;
   logic [RA_W-1:0] r_ex_rs;
   logic [RA_W-1:0] r_ex_rt;

   logic            r_mem_mem_read;
   logic            r_mem_mem_write;
   logic            r_mem_reg_write;
   logic            r_mem_mem_to_reg;
   logic [RA_W-1:0] r_mem_dest;

   logic            r_wb_reg_write;
   logic            r_wb_mem_to_reg;
   logic [RA_W-1:0] r_wb_waddr;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      w_dec       = '0;
      w_alu       = ALU_ADD;
      w_known     = 1'b0;
      w_imm_arith = 1'b0;
      w_reg_dst   = 1'b0;
      w_rt_src    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            w_known         = 1'b1;
            w_rt_src        = 1'b1;
            w_dec.reg_write = 1'b1;
            case (funcode)
               F_ADD, F_ADDU: w_alu = ALU_ADD;
               F_SUB, F_SUBU: w_alu = ALU_SUB;
               F_AND:         w_alu = ALU_AND;
               F_OR:          w_alu = ALU_OR;
               F_NOR:         w_alu = ALU_NOR;
               F_SLT:         w_alu = ALU_SLT;
               F_SLL:         w_alu = ALU_SLL;
               F_SRL:         w_alu = ALU_SRL;
               F_SRA:         w_alu = ALU_SRA;
               F_JR: begin
                  w_dec.reg_write = 1'b0;
                  w_dec.is_jr     = 1'b1;
               end
               default: begin
                  w_known         = 1'b0;
                  w_dec.reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin w_imm_arith = 1'b1; w_alu = ALU_ADD; end
         OP_ANDI:           begin w_imm_arith = 1'b1; w_alu = ALU_AND; end
         OP_ORI:            begin w_imm_arith = 1'b1; w_alu = ALU_OR;  end
         OP_SLTI:           begin w_imm_arith = 1'b1; w_alu = ALU_SLT; end
         OP_LUI:            begin w_imm_arith = 1'b1; w_alu = ALU_LUI; end
         OP_LW: begin
            w_known          = 1'b1;
            w_reg_dst        = 1'b1;
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.alu_src    = 1'b1;
         end
         OP_SW: begin
            w_known         = 1'b1;
            w_rt_src        = 1'b1;
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            w_known         = 1'b1;
            w_rt_src        = 1'b1;
            w_dec.is_branch = 1'b1;
            w_alu           = ALU_SUB;
         end
         OP_BNE: begin
            w_known         = 1'b1;
            w_rt_src        = 1'b1;
            w_dec.is_branch = 1'b1;
            w_alu           = ALU_BNE;
         end
         OP_BGTZ: begin
            w_known         = 1'b1;
            w_dec.is_branch = 1'b1;
            w_alu           = ALU_BGTZ;
         end
         OP_REGIMM: begin
            w_known         = 1'b1;
            w_dec.is_branch = 1'b1;
            w_alu           = ALU_BGEZ;
         end
         default: ;
      endcase
      if (w_imm_arith) begin
         w_known         = 1'b1;
         w_reg_dst       = 1'b1;
         w_dec.reg_write = 1'b1;
         w_dec.alu_src   = 1'b1;
      end
      w_dec.alu_op = ALUOP_W'(w_alu);
      w_dest       = w_reg_dst ? id_rt : id_rd;
      // Register 0 is hard-wired, so a write to it is dropped at decode.
      if (w_dest == '0) w_dec.reg_write = 1'b0;
   end

   assign illegal_instr = id_valid & ~w_known;

   always_comb begin
      w_load_use = r_ex_valid && r_ex.mem_read && id_valid && (r_ex_dest != '0) &&
                   ((r_ex_dest == id_rs) || (w_rt_src && (r_ex_dest == id_rt)));
      w_redir_br = r_ex_valid & r_ex.is_branch & branch_taken;
      w_redir_jr = r_ex_valid & r_ex.is_jr;
      w_id_bubble = w_redir_br | w_redir_jr | w_load_use | ~id_valid | ~w_known;

      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      pc_src     = 2'b00;
      // A redirect squashes the ID instruction, so any stall it caused is moot.
      if (w_redir_br || w_redir_jr) begin
         ifid_flush = 1'b1;
         pc_src     = w_redir_br ? 2'b10 : 2'b01;
      end else if (w_load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage samples
   // its predecessor's value from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex_valid       <= 1'b0;
         r_ex             <= '0;
         r_ex_dest        <= '0;
         r_ex_rs          <= '0;
         r_ex_rt          <= '0;
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_dest       <= '0;
         r_wb_reg_write   <= 1'b0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_waddr       <= '0;
      end else begin
         if (w_id_bubble) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
            r_ex_dest  <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
         end else begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_dec;
            r_ex_dest  <= w_dest;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
         end
         r_mem_mem_read   <= r_ex.mem_read;
         r_mem_mem_write  <= r_ex.mem_write;
         r_mem_reg_write  <= r_ex.reg_write;
         r_mem_mem_to_reg <= r_ex.mem_to_reg;
         r_mem_dest       <= r_ex_dest;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_waddr       <= r_mem_dest;
      end
   end

   // MEM is the younger producer, so its match takes priority over WB.
   always_comb begin
      ex_fwd_a = 2'b00;
      ex_fwd_b = 2'b00;
      if (FWD_EN && r_ex_valid) begin
         if (r_mem_reg_write && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs))
            ex_fwd_a = 2'b10;
         else if (r_wb_reg_write && (r_wb_waddr != '0) && (r_wb_waddr == r_ex_rs))
            ex_fwd_a = 2'b01;
         if (r_mem_reg_write && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt))
            ex_fwd_b = 2'b10;
         else if (r_wb_reg_write && (r_wb_waddr != '0) && (r_wb_waddr == r_ex_rt))
            ex_fwd_b = 2'b01;
      end
   end

   assign ex_valid      = r_ex_valid;
   assign ex_alu_op     = r_ex.alu_op;
   assign ex_alu_src    = r_ex.alu_src;
   assign mem_mem_read  = r_mem_mem_read;
   assign mem_mem_write = r_mem_mem_write;
   assign wb_reg_write  = r_wb_reg_write;
   assign wb_mem_to_reg = r_wb_mem_to_reg;
   assign wb_waddr      = r_wb_waddr;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: hazards, redirects, forwarding and decode
// checked against hand-computed expectations.
module tb_pipe_ctrl_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BGEZ = 6'b000001;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGTZ = 6'b000111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_JR    = 6'b001000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [5:0] opcode;
   logic [5:0] funcode;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       branch_taken;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic [1:0] pc_src;
   logic       illegal_instr;
   logic       ex_valid;
   logic [4:0] ex_alu_op;
   logic       ex_alu_src;
   logic [1:0] ex_fwd_a;
   logic [1:0] ex_fwd_b;
   logic       mem_mem_read;
   logic       mem_mem_write;
   logic       wb_reg_write;
   logic       wb_mem_to_reg;
   logic [4:0] wb_waddr;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_ctrl_unit #(.ALUOP_W(5), .RA_W(5), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
      .funcode(funcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .pc_src(pc_src), .illegal_instr(illegal_instr),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
      .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .wb_reg_write(wb_reg_write),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_waddr(wb_waddr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      id_valid = v;
      opcode   = op;
      funcode  = fn;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      branch_taken = 1'b0;
      instr(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0);
      tick();
      tick();
      check("rst_ex_valid",   32'(ex_valid), 0);
      check("rst_ex_alu_op",  32'(ex_alu_op), 0);
      check("rst_ex_alu_src", 32'(ex_alu_src), 0);
      check("rst_mem_read",   32'(mem_mem_read), 0);
      check("rst_mem_write",  32'(mem_mem_write), 0);
      check("rst_wb_regw",    32'(wb_reg_write), 0);
      check("rst_wb_m2r",     32'(wb_mem_to_reg), 0);
      check("rst_wb_waddr",   32'(wb_waddr), 0);
      check("rst_pc_write",   32'(pc_write), 1);
      check("rst_ifid_write", 32'(ifid_write), 1);
      check("rst_ifid_flush", 32'(ifid_flush), 0);
      check("rst_pc_src",     32'(pc_src), 0);
      check("rst_fwd_a",      32'(ex_fwd_a), 0);
      check("rst_fwd_b",      32'(ex_fwd_b), 0);
      rst_n = 1'b1;
      instr(1'b0, OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
      tick();

      // lw $2,0($1) ; add $3,$2,$4 -> one stall cycle, then WB forward
      instr(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0);
      check("lw_illegal", 32'(illegal_instr), 0);
      check("lw_pc_write", 32'(pc_write), 1);
      tick();
      instr(1'b1, OP_R, F_ADD, 5'd2, 5'd4, 5'd3);
      check("lu_pc_write", 32'(pc_write), 0);
      check("lu_ifid_write", 32'(ifid_write), 0);
      check("lu_ex_valid", 32'(ex_valid), 1);
      check("lu_ex_alu_src", 32'(ex_alu_src), 1);
      tick();
      check("lu_bubble_valid", 32'(ex_valid), 0);
      check("lu_after_pc_write", 32'(pc_write), 1);
      check("lu_after_ifid_write", 32'(ifid_write), 1);
      check("lu_mem_read", 32'(mem_mem_read), 1);
      tick();
      check("add3_ex_valid", 32'(ex_valid), 1);
      check("add3_fwd_a", 32'(ex_fwd_a), 1);
      check("add3_fwd_b", 32'(ex_fwd_b), 0);
      check("lw_wb_regw", 32'(wb_reg_write), 1);
      check("lw_wb_m2r", 32'(wb_mem_to_reg), 1);
      check("lw_wb_waddr", 32'(wb_waddr), 2);
      check("add3_alu_op", 32'(ex_alu_op), 0);
      check("add3_alu_src", 32'(ex_alu_src), 0);

      // add $2,$6,$7 ; add $5,$2,$2 ; sub $5,$5,$5 ; or $9,$5,$2 ; addi $0,$0,5
      instr(1'b1, OP_R, F_ADD, 5'd6, 5'd7, 5'd2);
      tick();
      instr(1'b1, OP_R, F_ADD, 5'd2, 5'd2, 5'd5);
      tick();
      check("add5_fwd_a", 32'(ex_fwd_a), 2);
      check("add5_fwd_b", 32'(ex_fwd_b), 2);
      check("add3_wb_waddr", 32'(wb_waddr), 3);
      check("add3_wb_regw", 32'(wb_reg_write), 1);
      instr(1'b1, OP_R, F_SUB, 5'd5, 5'd5, 5'd5);
      tick();
      check("sub_alu_op", 32'(ex_alu_op), 1);
      check("sub_fwd_a", 32'(ex_fwd_a), 2);
      check("sub_fwd_b", 32'(ex_fwd_b), 2);
      instr(1'b1, OP_R, F_OR, 5'd5, 5'd2, 5'd9);
      tick();
      check("or_alu_op", 32'(ex_alu_op), 3);
      check("or_fwd_a_mem_wins", 32'(ex_fwd_a), 2);
      check("or_fwd_b", 32'(ex_fwd_b), 0);
      instr(1'b1, OP_ADDI, 6'd0, 5'd0, 5'd0, 5'd0);
      tick();
      check("addi_alu_src", 32'(ex_alu_src), 1);
      check("addi_alu_op", 32'(ex_alu_op), 0);
      check("addi_fwd_a", 32'(ex_fwd_a), 0);
      check("sub_wb_waddr", 32'(wb_waddr), 5);
      instr(1'b0, OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
      tick();
      check("idle_ex_valid", 32'(ex_valid), 0);
      check("idle_fwd_a", 32'(ex_fwd_a), 0);
      check("or_wb_waddr", 32'(wb_waddr), 9);
      tick();
      check("addi0_wb_regw", 32'(wb_reg_write), 0);
      check("addi0_wb_waddr", 32'(wb_waddr), 0);

      // beq taken in EX -> redirect and squash
      instr(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
      tick();
      check("beq_alu_op", 32'(ex_alu_op), 1);
      check("beq_alu_src", 32'(ex_alu_src), 0);
      branch_taken = 1'b1;
      instr(1'b1, OP_R, F_ADD, 5'd2, 5'd4, 5'd3);
      check("beq_pc_src", 32'(pc_src), 2);
      check("beq_flush", 32'(ifid_flush), 1);
      check("beq_pc_write", 32'(pc_write), 1);
      check("beq_ifid_write", 32'(ifid_write), 1);
      tick();
      check("beq_squash_valid", 32'(ex_valid), 0);
      check("beq_squash_alu_op", 32'(ex_alu_op), 0);
      branch_taken = 1'b0;
      instr(1'b1, OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0);
      check("post_beq_pc_src", 32'(pc_src), 0);
      check("post_beq_flush", 32'(ifid_flush), 0);
      tick();
      check("bne_alu_op", 32'(ex_alu_op), 10);
      instr(1'b1, OP_R, F_JR, 5'd31, 5'd0, 5'd0);
      check("bne_nt_pc_src", 32'(pc_src), 0);
      check("bne_nt_flush", 32'(ifid_flush), 0);
      tick();
      check("jr_pc_src", 32'(pc_src), 1);
      check("jr_flush", 32'(ifid_flush), 1);
      check("jr_ex_valid", 32'(ex_valid), 1);
      instr(1'b1, OP_R, F_ADD, 5'd2, 5'd4, 5'd3);
      tick();
      check("jr_after_pc_src", 32'(pc_src), 0);
      check("jr_squash_valid", 32'(ex_valid), 0);
      instr(1'b0, OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
      tick();
      check("jr_wb_regw", 32'(wb_reg_write), 0);

      instr(1'b1, OP_BGTZ, 6'd0, 5'd1, 5'd0, 5'd0);
      tick();
      check("bgtz_alu_op", 32'(ex_alu_op), 11);
      instr(1'b1, OP_BGEZ, 6'd0, 5'd1, 5'd1, 5'd0);
      tick();
      check("bgez_alu_op", 32'(ex_alu_op), 12);

      // illegal opcode and funcode
      instr(1'b1, OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3);
      check("bad_op_illegal", 32'(illegal_instr), 1);
      instr(1'b1, OP_R, 6'b111111, 5'd1, 5'd2, 5'd3);
      check("bad_fn_illegal", 32'(illegal_instr), 1);
      instr(1'b0, OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3);
      check("bad_invalid_illegal", 32'(illegal_instr), 0);
      instr(1'b1, OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3);
      tick();
      check("bad_ex_valid", 32'(ex_valid), 0);
      check("bad_ex_alu_op", 32'(ex_alu_op), 0);
      check("bad_ex_alu_src", 32'(ex_alu_src), 0);

      // lw $2 ; sw $2,0($1) stalls via rt; lw to $0 never stalls
      instr(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0);
      tick();
      instr(1'b1, OP_SW, 6'd0, 5'd1, 5'd2, 5'd0);
      check("sw_rt_stall", 32'(pc_write), 0);
      tick();
      check("sw_bubble_valid", 32'(ex_valid), 0);
      check("sw_stall_released", 32'(pc_write), 1);
      tick();
      check("sw_fwd_b", 32'(ex_fwd_b), 1);
      check("sw_fwd_a", 32'(ex_fwd_a), 0);
      check("sw_alu_src", 32'(ex_alu_src), 1);
      instr(1'b1, OP_LW, 6'd0, 5'd1, 5'd0, 5'd0);
      tick();
      check("sw_mem_write", 32'(mem_mem_write), 1);
      check("sw_mem_read", 32'(mem_mem_read), 0);
      instr(1'b1, OP_R, F_ADD, 5'd0, 5'd0, 5'd3);
      check("lw0_no_stall", 32'(pc_write), 1);
      tick();
      check("lw0_mem_read", 32'(mem_mem_read), 1);
      instr(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0);
      tick();
      check("lw0_wb_regw", 32'(wb_reg_write), 0);
      instr(1'b1, OP_ADDI, 6'd0, 5'd3, 5'd2, 5'd0);
      check("addi_rt_no_stall", 32'(pc_write), 1);
      tick();
      instr(1'b1, OP_LUI, 6'd0, 5'd0, 5'd4, 5'd0);
      tick();
      check("lui_alu_op", 32'(ex_alu_op), 9);
      check("lui_alu_src", 32'(ex_alu_src), 1);

      // reset during a stall discards in-flight state
      instr(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0);
      tick();
      instr(1'b1, OP_R, F_ADD, 5'd2, 5'd4, 5'd3);
      check("pre_rst_stall", 32'(pc_write), 0);
      rst_n = 1'b0;
      tick();
      check("midrst_ex_valid", 32'(ex_valid), 0);
      check("midrst_pc_write", 32'(pc_write), 1);
      check("midrst_ifid_write", 32'(ifid_write), 1);
      check("midrst_mem_read", 32'(mem_mem_read), 0);
      check("midrst_wb_regw", 32'(wb_reg_write), 0);
      rst_n = 1'b1;
      instr(1'b0, OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
